// File: rtl/nibble_serial_adder.sv
// Serial adder: processes one 4-bit nibble per clock through a carry-lookahead
// stage, producing a registered W-bit sum, carry-out and signed overflow flag.
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              cin,
    output logic [4*NIB-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [NIB-1:0][3:0]  a_reg, b_reg, sum_reg;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic                 last;
    logic                 accept;
    logic [3:0]           an, bn, p, g, s;
    logic                 c1, c2, c3, c4;

    assign last   = (idx == IW'(NIB - 1));
    assign accept = start && (state != RUN);

    assign an = a_reg[idx];
    assign bn = b_reg[idx];
    assign p  = an ^ bn;
    assign g  = an & bn;

    // Carries flattened into lookahead form so each depends only on P, G and the carry register
    assign c1 = g[0] | (p[0] & carry);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry);
    assign s  = p ^ {c3, c2, c1, carry};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[idx] <= s;
            carry        <= c4;
            if (last) begin
                // Index wraps here so it never reaches NIB
                idx  <= '0;
                cout <= c4;
                ovf  <= c3 ^ c4;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign sum  = sum_reg;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus
// randomized additions compared against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b, sum;
    logic         cout, ovf, busy, done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    // Reference: full-width unsigned addition, overflow from operand/result signs
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        ref_add = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        ref_ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Operand inputs are scrambled after the start edge to prove they were captured
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, output int lat);
        drive_start(av, bv, cv);
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        wait_done(lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_start(16'hABCD, 16'h1234, 1'b1);
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (sum !== '0) $display("[TB] FAIL reset_sum: got %h expected 0000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("[TB] FAIL reset_cout: got %b expected 0", cout); else passed++;
        total++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); else passed++;
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF};
        logic [W-1:0] vb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF};
        logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W:0]   exp;
        logic         eovf;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            run_add(va[i], vb[i], vc[i], lat);
            exp  = ref_add(va[i], vb[i], vc[i]);
            eovf = ref_ovf(va[i], vb[i], vc[i]);
            total++; if (lat != NIB) $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, NIB); else passed++;
            total++; if (sum !== exp[W-1:0]) $display("[TB] FAIL directed%0d_sum: got %h expected %h", i, sum, exp[W-1:0]); else passed++;
            total++; if (cout !== exp[W]) $display("[TB] FAIL directed%0d_cout: got %b expected %b", i, cout, exp[W]); else passed++;
            total++; if (ovf !== eovf) $display("[TB] FAIL directed%0d_ovf: got %b expected %b", i, ovf, eovf); else passed++;
            total++; if (busy !== 1'b0) $display("[TB] FAIL directed%0d_busy: got %b expected 0", i, busy); else passed++;
            tick();
            total++; if (done !== 1'b0) $display("[TB] FAIL directed%0d_done_drop: got %b expected 0", i, done); else passed++;
            total++; if (sum !== exp[W-1:0]) $display("[TB] FAIL directed%0d_sum_hold: got %h expected %h", i, sum, exp[W-1:0]); else passed++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc, eovf;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 1) == 1) tick();
            run_add(ra, rb, rc, lat);
            exp  = ref_add(ra, rb, rc);
            eovf = ref_ovf(ra, rb, rc);
            total++; if (lat != NIB) $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, NIB); else passed++;
            total++; if (sum !== exp[W-1:0]) $display("[TB] FAIL random%0d_sum: got %h expected %h", i, sum, exp[W-1:0]); else passed++;
            total++; if (cout !== exp[W]) $display("[TB] FAIL random%0d_cout: got %b expected %b", i, cout, exp[W]); else passed++;
            total++; if (ovf !== eovf) $display("[TB] FAIL random%0d_ovf: got %b expected %b", i, ovf, eovf); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        tick();
        drive_start(16'h1111, 16'h2222, 1'b0);
        tick();
        start = 1'b0;
        tick();
        drive_start(16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        start = 1'b0;
        wait_done(lat);
        total++; if (lat != NIB - 2) $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, NIB - 2); else passed++;
        total++; if (sum !== 16'h3333) $display("[TB] FAIL ignore_sum: got %h expected 3333", sum); else passed++;
        total++; if (cout !== 1'b0) $display("[TB] FAIL ignore_cout: got %b expected 0", cout); else passed++;
    endtask

    task automatic test_reset_midrun();
        int lat;
        drive_start(W'($urandom), W'($urandom), 1'b1);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else passed++;
        total++; if (sum !== '0) $display("[TB] FAIL midreset_sum: got %h expected 0000", sum); else passed++;
        rst_n = 1'b1;
        run_add(16'h0F0F, 16'h00F1, 1'b0, lat);
        total++; if (lat != NIB) $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, NIB); else passed++;
        total++; if (sum !== 16'h1000) $display("[TB] FAIL midreset_sum2: got %h expected 1000", sum); else passed++;
        total++; if (cout !== 1'b0) $display("[TB] FAIL midreset_cout: got %b expected 0", cout); else passed++;
    endtask

    task automatic test_back_to_back();
        int         lat;
        logic [W:0] exp;
        run_add(16'h1234, 16'h1111, 1'b0, lat);
        total++; if (sum !== 16'h2345) $display("[TB] FAIL b2b_first_sum: got %h expected 2345", sum); else passed++;
        drive_start(16'h8000, 16'h8000, 1'b0);
        tick();
        total++; if (done !== 1'b0) $display("[TB] FAIL b2b_done: got %b expected 0", done); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_busy: got %b expected 1", busy); else passed++;
        start = 1'b0;
        wait_done(lat);
        exp = ref_add(16'h8000, 16'h8000, 1'b0);
        total++; if (lat != NIB) $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, NIB); else passed++;
        total++; if (sum !== exp[W-1:0]) $display("[TB] FAIL b2b_sum: got %h expected %h", sum, exp[W-1:0]); else passed++;
        total++; if (cout !== 1'b1) $display("[TB] FAIL b2b_cout: got %b expected 1", cout); else passed++;
        total++; if (ovf !== 1'b1) $display("[TB] FAIL b2b_ovf: got %b expected 1", ovf); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIB, default 4, the number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port a, input, W bits: operand A.
REQ-006 SHALL have port b, input, W bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in to nibble 0.
REQ-008 SHALL have port sum, output, W bits: registered result.
REQ-009 SHALL have port cout, output, 1 bit: registered carry out of the MSB.
REQ-010 SHALL have port ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when sum, cout and ovf are valid.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 at edge E0: SHALL capture a, b and cin into internal registers, clear the nibble index to 0 and the carry register to cin, and enter RUN.
REQ-015 start=1 while in RUN SHALL be ignored; captured operands are unchanged.
REQ-016 In RUN, each edge SHALL add nibble i of A and B plus the carry register using 4-bit carry-lookahead (P=a^b, G=a&b, C[k+1]=G[k]|P[k]&C[k]), write the nibble result into sum[4i+3:4i], load the carry register with the nibble carry-out, and increment i.
REQ-017 Nibble i SHALL be written at edge E(i+1); at edge E(NIB), FSM SHALL enter DONE, cout = final carry, ovf = carry into MSB XOR carry out of MSB.
REQ-018 Latency: done SHALL be high exactly during the cycle after edge E(NIB) (4 cycles after the start edge at NIB=4), then return low at the next edge unless REQ-014 restarts.
REQ-019 busy SHALL be 1 from edge E0 until edge E(NIB), and 0 in IDLE and DONE.
REQ-020 sum SHALL be valid only while done=1 or afterward; sum, cout and ovf SHALL hold until the next accepted start. During RUN, sum holds partial nibbles and is not valid.
REQ-021 Arithmetic SHALL be unsigned modulo 2^W with carry to cout; there are no wider intermediates beyond a 5-bit nibble sum.
REQ-022 Back-to-back: start in DONE SHALL be accepted at that edge (DONE->RUN, done=0, busy=1 next cycle).
REQ-023 DONE with start=0 SHALL return to IDLE at the next edge.
REQ-024 Nibble index SHALL wrap only via the FSM; no index value >= NIB is ever used.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, index=0, carry register=0, and operand registers=0, regardless of state, including mid-RUN.
REQ-026 While rst_n=0, start SHALL be ignored; the first accepted start is the first edge with rst_n=1 and start=1.

Verification
REQ-027 a=0x1234, b=0x4321, cin=0, start pulsed -> 4 cycles later done=1, sum=0x5555, cout=0, ovf=0, busy low same cycle.
REQ-028 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates through all 4 nibbles).
REQ-029 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; and a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
REQ-030 Start 0x1111+0x2222, then start again 2 cycles later with 0xFFFF+0xFFFF -> second start ignored; done shows sum=0x3333, cout=0.
REQ-031 rst_n driven 0 after nibble 1 written -> next edge: busy=0, done=0, sum=0; subsequent start 0x0F0F+0x00F1 -> sum=0x1000, cout=0.
REQ-032 Start held high through the DONE cycle with new operands 0x8000+0x8000 -> accepted, done low next cycle, 4 cycles later sum=0x0000, cout=1, ovf=1.
